// File: rtl/auto_player.sv
// auto_player: waits for a stable one-hot-low segment pattern on the game display and presses the matching button.
// Define AUTO_RESTART_EN to have the player press button 0 after game over and resume play.
`timescale 1ns/1ps
module auto_player #(
    parameter int STABLE_CYCLES = 2,
    parameter int REACT_CYCLES  = 2,
    parameter int HOLD_CYCLES   = 8,
    parameter int GAP_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [6:0] seg_in,
    input  logic       dp_in,
    input  logic [7:0] score_in,
    output logic [7:0] btn_out,
    output logic [7:0] hits,
    output logic       game_over,
    output logic [7:0] final_score,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, SETTLE, REACT, PRESS, RELEASE, OVER} state_t;

    localparam int OVER_CYCLES = 2 * GAP_CYCLES + HOLD_CYCLES;
    localparam int PH_MAX      = (REACT_CYCLES > OVER_CYCLES) ? REACT_CYCLES : OVER_CYCLES;
    localparam int PH_W        = $clog2(PH_MAX + 1);
    localparam int CNT_W       = $clog2(STABLE_CYCLES + 2);

    localparam logic [PH_W-1:0]  REACT_LAST = PH_W'(REACT_CYCLES - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CYCLES);
`ifdef AUTO_RESTART_EN
    localparam logic [PH_W-1:0]  OVER_LAST  = PH_W'(OVER_CYCLES - 1);
    localparam logic [PH_W-1:0]  RST_FIRST  = PH_W'(GAP_CYCLES);
    localparam logic [PH_W-1:0]  RST_END    = PH_W'(GAP_CYCLES + HOLD_CYCLES);
`endif

    state_t           r_state, w_state_next;
    logic [PH_W-1:0]  r_phase, w_phase_next;
    logic [7:0]       r_sample;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_target;
    logic [7:0]       r_btn, w_btn_next;
    logic [7:0]       r_hits;
    logic             r_game_over;
    logic [7:0]       r_final;
    logic             r_err;

    logic [6:0] w_low;
    logic       w_one_low;
    logic       w_stable;
    logic       w_dp;

    assign w_low     = ~r_sample[6:0];
    assign w_one_low = (w_low != 7'd0) && ((w_low & (w_low - 7'd1)) == 7'd0);
    assign w_stable  = (r_cnt >= CNT_STABLE);
    assign w_dp      = r_sample[7];

    // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (enable) w_state_next = SETTLE;
            SETTLE:  if (w_stable) begin
                         if (!w_dp)          w_state_next = OVER;
                         else if (w_one_low) w_state_next = REACT;
                     end
            REACT:   if (r_phase == REACT_LAST) w_state_next = PRESS;
            PRESS:   if (r_phase == HOLD_LAST)  w_state_next = RELEASE;
            RELEASE: if (r_phase == GAP_LAST)   w_state_next = SETTLE;
`ifdef AUTO_RESTART_EN
            OVER:    if (r_phase == OVER_LAST)  w_state_next = SETTLE;
`else
            OVER:    w_state_next = OVER;
`endif
            default: w_state_next = IDLE;
        endcase
        if (!enable) w_state_next = IDLE;

        w_phase_next = '0;
        if (enable && w_state_next == r_state &&
            (r_state == REACT || r_state == PRESS || r_state == RELEASE || r_state == OVER))
            w_phase_next = r_phase + 1'b1;
    end

    // Button drive is decided from the upcoming state so the register changes on the state edge itself.
    always_comb begin
        w_btn_next = 8'h00;
        if (w_state_next == PRESS) w_btn_next = r_target;
`ifdef AUTO_RESTART_EN
        else if (w_state_next == OVER && w_phase_next >= RST_FIRST && w_phase_next < RST_END)
            w_btn_next = 8'h01;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_sample    <= '0;
            r_cnt       <= '0;
            r_target    <= '0;
            r_btn       <= '0;
            r_hits      <= '0;
            r_game_over <= 1'b0;
            r_final     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_phase     <= w_phase_next;
            r_sample    <= {dp_in, seg_in};
            r_btn       <= w_btn_next;
            r_game_over <= (w_state_next == OVER);

            // A return to SETTLE restarts the stability wait so the same pattern is re-qualified.
            if (!enable || (w_state_next == SETTLE && (r_state == RELEASE || r_state == OVER)))
                r_cnt <= '0;
            else if ({dp_in, seg_in} == r_sample)
                r_cnt <= (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
            else
                r_cnt <= '0;

            if (r_state == SETTLE && w_state_next == REACT) r_target <= {1'b0, w_low};
            if (r_state == SETTLE && w_state_next == OVER)  r_final  <= score_in;
            if (w_state_next == PRESS && r_state != PRESS && r_hits != 8'hFF)
                r_hits <= r_hits + 8'd1;
            if (enable && r_state == SETTLE && w_stable && w_dp && !w_one_low)
                r_err <= 1'b1;
        end
    end

    assign btn_out     = r_btn;
    assign hits        = r_hits;
    assign game_over   = r_game_over;
    assign final_score = r_final;
    assign err         = r_err;
endmodule

// File: tb/tb_auto_player.sv
// Self-checking bench for auto_player: directed scenarios then randomized display traffic,
// each cycle compared against a press-schedule model of the player.
`timescale 1ns/1ps
module tb_auto_player;
    localparam int STABLE = 2;
    localparam int REACT  = 2;
    localparam int HOLD   = 8;
    localparam int GAP    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic       dp_in = 1'b1;
    logic [7:0] score_in = 8'h00;
    logic [7:0] btn_out, hits, final_score;
    logic       game_over, err;

    auto_player #(.STABLE_CYCLES(STABLE), .REACT_CYCLES(REACT),
                  .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .enable(enable), .seg_in(seg_in), .dp_in(dp_in),
        .score_in(score_in), .btn_out(btn_out), .hits(hits), .game_over(game_over),
        .final_score(final_score), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: a queue of planned button values, one per upcoming cycle.
    typedef struct { logic [7:0] btn; bit hit; } act_t;
    act_t       plan[$];
    logic [7:0] m_sample = '0;
    int         m_cnt = 0;
    bit         m_active = 0, m_busy = 0, m_over = 0;
    logic [7:0] m_btn = '0, m_hits = '0, m_final = '0;
    bit         m_go = 0, m_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic schedule(input logic [7:0] b, input int n, input bit first_hit);
        for (int i = 0; i < n; i++) begin
            act_t a;
            a.btn = b;
            a.hit = first_hit && (i == 0);
            plan.push_back(a);
        end
    endtask

    function automatic logic [7:0] target_of(input logic [6:0] s);
        logic [7:0] t = 8'h00;
        for (int k = 0; k < 7; k++) if (!s[k]) t = 8'h01 << k;
        return t;
    endfunction

    task automatic model_step();
        logic [7:0] in_s, old_s;
        int old_c;
        bit clr;
        act_t a;
        in_s = {dp_in, seg_in};
        if (rst) begin
            plan.delete();
            m_sample = '0; m_cnt = 0; m_active = 0; m_busy = 0; m_over = 0;
            m_btn = '0; m_hits = '0; m_final = '0; m_go = 0; m_err = 0;
            return;
        end
        if (!enable) begin
            plan.delete();
            m_active = 0; m_busy = 0; m_over = 0; m_go = 0; m_btn = '0;
            m_cnt = 0; m_sample = in_s;
            return;
        end
        old_s = m_sample; old_c = m_cnt; clr = 0; m_btn = '0;
        if (!m_active) m_active = 1;
        else if (m_busy) begin
            if (plan.size() == 0) begin
                m_busy = 0; m_over = 0; m_go = 0; clr = 1;
            end
        end else if (!m_over && old_c >= STABLE) begin
            if (!old_s[7]) begin
                m_over = 1; m_go = 1; m_final = score_in;
`ifdef AUTO_RESTART_EN
                schedule(8'h00, GAP, 0); schedule(8'h01, HOLD, 0); schedule(8'h00, GAP, 0);
                m_busy = 1;
`endif
            end else if ($countones(~old_s[6:0]) == 1) begin
                schedule(8'h00, REACT, 0); schedule(target_of(old_s[6:0]), HOLD, 1);
                schedule(8'h00, GAP, 0);
                m_busy = 1;
            end else m_err = 1;
        end
        if (m_busy && plan.size() > 0) begin
            a = plan.pop_front();
            m_btn = a.btn;
            if (a.hit && m_hits != 8'hFF) m_hits++;
        end
        if (clr) m_cnt = 0;
        else if (in_s == old_s) m_cnt = (m_cnt < 1000) ? m_cnt + 1 : m_cnt;
        else m_cnt = 0;
        m_sample = in_s;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("btn@%0d", cyc),   btn_out,     m_btn);
        check($sformatf("hits@%0d", cyc),  hits,        m_hits);
        check($sformatf("go@%0d", cyc),    game_over,   m_go);
        check($sformatf("final@%0d", cyc), final_score, m_final);
        check($sformatf("err@%0d", cyc),   err,         m_err);
    endtask

    initial begin
        int run, max_run, nz, pressed, r, len, k;
        logic [6:0] one;

        // Reset held for two cycles.
        rst = 1; enable = 0;
        tick(); tick();
        check("s035_btn", btn_out, 8'h00);
        check("s035_hits", hits, 8'd0);
        check("s035_go", game_over, 1'b0);
        check("s035_final", final_score, 8'd0);
        check("s035_err", err, 1'b0);

        // Steady seg bit 3 low: two presses of 8'h08, 8 cycles each.
        rst = 0; enable = 1; dp_in = 1; seg_in = 7'b1110111;
        run = 0; max_run = 0;
        for (int i = 0; i < 29; i++) begin
            tick();
            run = (btn_out == 8'h08) ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        check("s036_hits", hits, 8'd2);
        check("s036_run", max_run, 8);

        // Third cycle of the second press: drop enable.
        enable = 0;
        tick();
        check("s040_en_btn", btn_out, 8'h00);
        check("s040_en_hits", hits, 8'd2);

        // Press again, then reset in the third press cycle.
        enable = 1;
        pressed = 0;
        for (int i = 0; i < 40 && pressed < 3; i++) begin
            tick();
            if (m_btn != 8'h00) pressed++;
        end
        check("s040_reached_press", pressed, 3);
        rst = 1;
        tick();
        check("s040_rst_btn", btn_out, 8'h00);
        check("s040_rst_hits", hits, 8'd0);

        // Alternating pattern never settles.
        rst = 0; enable = 1; nz = 0;
        for (int i = 0; i < 24; i++) begin
            seg_in = i[0] ? 7'b1111101 : 7'b1111110;
            tick();
            if (btn_out != 8'h00) nz++;
        end
        check("s037_hits", hits, 8'd0);
        check("s037_btn_cycles", nz, 0);

        // Blank display flags err; err persists through a later valid press.
        seg_in = 7'b1111111;
        for (int i = 0; i < 6; i++) tick();
        check("s039_err", err, 1'b1);
        check("s039_hits", hits, 8'd0);
        seg_in = 7'b1111110;
        for (int i = 0; i < 20; i++) tick();
        check("s039_hits_after", hits, 8'd1);
        check("s039_err_sticky", err, 1'b1);

        // Game over with score 23.
        rst = 1; tick();
        rst = 0; enable = 1; dp_in = 0; seg_in = 7'h7F; score_in = 8'd23;
        for (int i = 0; i < 6; i++) tick();
        check("s038_go", game_over, 1'b1);
        check("s038_final", final_score, 8'd23);
        run = 0; max_run = 0; nz = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (btn_out != 8'h00) nz++;
            run = (btn_out == 8'h01) ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
`ifdef AUTO_RESTART_EN
        check("s038_restart_run", max_run, 8);
`else
        check("s038_no_btn", nz, 0);
`endif
        check("s038_hits", hits, 8'd0);

        // Randomized display traffic.
        dp_in = 1; score_in = 0; one = 7'd1;
        for (int s = 0; s < 45; s++) begin
            r = $urandom_range(0, 10);
            len = $urandom_range(1, 25);
            enable = 1; rst = 0;
            if (r < 5) begin
                k = $urandom_range(0, 6);
                dp_in = 1; seg_in = ~(one << k);
            end else if (r < 7) begin
                dp_in = 1; seg_in = 7'($urandom);
            end else if (r == 7) begin
                dp_in = 0; score_in = 8'($urandom);
            end else if (r == 8) begin
                enable = 0;
            end else if (r == 10) begin
                rst = 1; len = 1;
            end
            for (int i = 0; i < len; i++) begin
                if (r == 9) seg_in = 7'($urandom);
                tick();
            end
        end
        rst = 0; enable = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/auto_player.md
AUTO_PLAYER -- requirements
Module: auto_player

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 2: consecutive identical {dp_in,seg_in} samples required before acting.
REQ-002 SHALL have parameter REACT_CYCLES, default 2 (min 1): cycles between target latch and press.
REQ-003 SHALL have parameter HOLD_CYCLES, default 8: cycles a button is held high, long enough to clear the 4-cycle debouncer.
REQ-004 SHALL have parameter GAP_CYCLES, default 8: cycles all buttons are held low after a press.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port enable, input, 1: player run enable.
REQ-008 SHALL have port seg_in, input, 7: game segment pads, active-low (uo_out[6:0]).
REQ-009 SHALL have port dp_in, input, 1: game dp pad; 1 means playing, 0 means game over (uo_out[7]).
REQ-010 SHALL have port score_in, input, 8: game score pads (uio_out).
REQ-011 SHALL have port btn_out, output, 8: button drive to game ui_in, active-high.
REQ-012 SHALL have port hits, output, 8: count of presses issued.
REQ-013 SHALL have port game_over, output, 1: game-over observed.
REQ-014 SHALL have port final_score, output, 8: score captured at game over.
REQ-015 SHALL have port err, output, 1: sticky flag for an invalid display pattern.

Function
REQ-016 SHALL register {dp_in,seg_in} every cycle and count consecutive cycles in which the sample equals the previous sample; any change resets the count to 0.
REQ-017 SHALL implement states IDLE, SETTLE, REACT, PRESS, RELEASE, OVER.
REQ-018 IDLE: btn_out=0; SHALL go to SETTLE when enable=1.
REQ-019 SETTLE: when the count reaches STABLE_CYCLES with dp=1 and exactly one seg bit low at index k, SHALL latch target k and go to REACT.
REQ-020 SETTLE: when the count reaches STABLE_CYCLES with dp=0, SHALL capture score_in into final_score, set game_over=1 and go to OVER.
REQ-021 SETTLE: when the count reaches STABLE_CYCLES with dp=1 and zero or more than one seg bit low, SHALL set err=1 and remain in SETTLE.
REQ-022 REACT SHALL last exactly REACT_CYCLES cycles, then go to PRESS.
REQ-023 PRESS: btn_out SHALL equal one-hot bit k for exactly HOLD_CYCLES cycles; hits SHALL increment once on PRESS entry and saturate at 255.
REQ-024 RELEASE: btn_out=0 for exactly GAP_CYCLES cycles, then SHALL go to SETTLE with the stability count cleared.
REQ-025 Pressing the same k as the previous target again SHALL be permitted; the release gap guarantees a fresh rising edge.
REQ-026 enable=0 in any state SHALL force IDLE on the next edge with btn_out=0 from that edge; counters SHALL clear; hits, final_score and err SHALL hold.
REQ-027 While enable=0 the display SHALL be ignored, and err SHALL NOT set.
REQ-028 game_over SHALL clear on leaving OVER.
REQ-029 btn_out SHALL be driven from a register and never be combinational from the inputs.

Reset
REQ-030 rst=1 at a clock edge SHALL force state IDLE with btn_out=0, hits=0, game_over=0, final_score=0, err=0, and all counters and sample registers 0.
REQ-031 rst SHALL take priority over enable and every state transition, including mid-PRESS, where btn_out SHALL drop on that edge.

Configuration
REQ-032 With macro AUTO_RESTART_EN defined, OVER SHALL wait GAP_CYCLES, drive btn_out=8'h01 for HOLD_CYCLES, then drive 0 for GAP_CYCLES, then go to SETTLE.
REQ-033 This restart press SHALL NOT increment hits.
REQ-034 Without AUTO_RESTART_EN, OVER SHALL hold btn_out=0 indefinitely and be exited only by enable=0 or rst.

Verification
REQ-035 Scenario: rst=1 for 2 cycles -> btn_out=0, hits=0, game_over=0, final_score=0, err=0.
REQ-036 Scenario: enable=1, dp=1, seg=7'b1110111 held -> btn_out=8'h08 for exactly 8 cycles starting 2 cycles after latch, hits=1, then 8 cycles of 0, then a repeat press with hits=2.
REQ-037 Scenario: seg alternating 7'b1111110 and 7'b1111101 every cycle -> no press, hits stays 0.
REQ-038 Scenario: dp=0 and score_in=8'd23 stable for 2 cycles -> game_over=1, final_score=23; with AUTO_RESTART_EN, btn_out=8'h01 for 8 cycles after an 8-cycle gap; without it, btn_out stays 0.
REQ-039 Scenario: dp=1, seg=7'b1111111 for 2 cycles -> err=1, no press; err stays 1 after a valid pattern until rst.
REQ-040 Scenario: enable dropped during cycle 3 of PRESS -> btn_out=0 next edge, state IDLE, hits unchanged; the same scenario with rst in place of enable clears hits to 0.
